// File: rtl/serial_word_tx.sv
// Parallel-to-serial framer: shifts WIDTH-bit words out LSB first with tx_start framing,
// forces GAP_CYCLES idle cycles between frames and buffers one pending word.
module serial_word_tx #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx_start,
    output logic             bit_out,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_PENU = CW'(WIDTH - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [WIDTH-1:0] hold, hold_d;
    logic             hold_full, hold_full_d;
    logic [CW-1:0]    bit_cnt, bit_cnt_d;
    logic [GW-1:0]    gap_cnt, gap_cnt_d;
    logic             tx_start_d, bit_out_d, frame_done_d;
    logic             xfer;

    assign data_ready = !hold_full && !reset;
    assign xfer       = data_valid && data_ready;
    assign busy       = (state != IDLE) || hold_full;

    always_comb begin
        state_d      = state;
        sreg_d       = sreg;
        hold_d       = hold;
        hold_full_d  = hold_full;
        bit_cnt_d    = bit_cnt;
        gap_cnt_d    = gap_cnt;
        tx_start_d   = 1'b0;
        bit_out_d    = 1'b0;
        frame_done_d = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_d    = SHIFT;
                    sreg_d     = data_in;
                    bit_cnt_d  = '0;
                    tx_start_d = 1'b1;
                    bit_out_d  = data_in[0];
                end
            end
            SHIFT: begin
                // Outputs are registered, so each edge presents the next bit.
                if (bit_cnt != BIT_LAST) begin
                    bit_cnt_d    = bit_cnt + 1'b1;
                    sreg_d       = sreg >> 1;
                    tx_start_d   = 1'b1;
                    bit_out_d    = sreg[1];
                    frame_done_d = (bit_cnt == BIT_PENU);
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
                if (xfer) begin
                    hold_d      = data_in;
                    hold_full_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt != GAP_LAST) begin
                    gap_cnt_d = gap_cnt + 1'b1;
                    if (xfer) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full) begin
                    state_d     = SHIFT;
                    sreg_d      = hold;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    tx_start_d  = 1'b1;
                    bit_out_d   = hold[0];
                end else if (xfer) begin
                    // A word arriving as the gap closes skips the holding register.
                    state_d    = SHIFT;
                    sreg_d     = data_in;
                    bit_cnt_d  = '0;
                    tx_start_d = 1'b1;
                    bit_out_d  = data_in[0];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx_start   <= 1'b0;
            bit_out    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            sreg       <= sreg_d;
            hold       <= hold_d;
            hold_full  <= hold_full_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            tx_start   <= tx_start_d;
            bit_out    <= bit_out_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (gap 1 and gap 3) checked every cycle against
// a timestamp-based frame model, plus directed scenarios with literal expectations.
module tb_serial_word_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic [1:0]   ts_w, bo_w, fd_w, bz_w, dr_w;

    int checks = 0;
    int failures = 0;

    logic [63:0] cts [2];
    logic [63:0] cbo [2];
    logic [63:0] cfd [2];
    logic [63:0] cbz [2];
    logic [63:0] cdr [2];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int lane, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane%0d got=%0h exp=%0h t=%0t", nm, lane, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int G = (gi == 0) ? 1 : 3;
        logic ts, bo, fd, bz, dr;

        serial_word_tx #(.WIDTH(W), .GAP_CYCLES(G)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .data_in    (data_in),
            .data_valid (data_valid),
            .data_ready (dr),
            .tx_start   (ts),
            .bit_out    (bo),
            .frame_done (fd),
            .busy       (bz)
        );

        assign ts_w[gi] = ts;
        assign bo_w[gi] = bo;
        assign fd_w[gi] = fd;
        assign bz_w[gi] = bz;
        assign dr_w[gi] = dr;

        // Model: a frame is a start cycle plus a word; the next frame may start
        // at start+W+G at the earliest.
        int           cyc = 0;
        int           start = 0;
        bit           active = 1'b0;
        bit           hf = 1'b0;
        bit           seen = 1'b0;
        logic [W-1:0] word = '0;
        logic [W-1:0] hold = '0;

        always @(posedge clk) begin
            int   endc;
            bit   inf;
            logic e_ts, e_bo, e_fd, e_bz, e_dr;
            cyc++;
            if (reset) begin
                active = 1'b0;
                hf     = 1'b0;
                seen   = 1'b1;
            end else begin
                endc = start + W + G;
                if (active && hf && cyc == endc) begin
                    start = cyc;
                    word  = hold;
                    hf    = 1'b0;
                end else if (data_valid && !hf) begin
                    if (!active || cyc >= endc) begin
                        start  = cyc;
                        word   = data_in;
                        active = 1'b1;
                    end else begin
                        hold = data_in;
                        hf   = 1'b1;
                    end
                end
            end
            inf  = active && cyc >= start && cyc < start + W;
            e_ts = inf;
            e_bo = inf ? word[cyc-start] : 1'b0;
            e_fd = active && cyc == start + W - 1;
            e_bz = (active && cyc < start + W + G) || hf;
            e_dr = !hf && !reset;
            #1;
            if (seen) begin
                chk("tx_start", gi, 64'(ts), 64'(e_ts));
                chk("bit_out", gi, 64'(bo), 64'(e_bo));
                chk("frame_done", gi, 64'(fd), 64'(e_fd));
                chk("busy", gi, 64'(bz), 64'(e_bz));
                chk("data_ready", gi, 64'(dr), 64'(e_dr));
            end
        end
    end

    task automatic offer(input logic [W-1:0] w);
        @(negedge clk);
        data_in    = w;
        data_valid = 1'b1;
    endtask

    // Sample i is the cycle after the i-th edge; actions fire right after sample i.
    task automatic cap(input int n, input int d2_at, input logic [W-1:0] d2,
                       input int drop_at, input int rst_at, input int rel_at);
        for (int l = 0; l < 2; l++) begin
            cts[l] = '0; cbo[l] = '0; cfd[l] = '0; cbz[l] = '0; cdr[l] = '0;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            for (int l = 0; l < 2; l++) begin
                cts[l][i] = ts_w[l];
                cbo[l][i] = bo_w[l];
                cfd[l][i] = fd_w[l];
                cbz[l][i] = bz_w[l];
                cdr[l][i] = dr_w[l];
            end
            if (i == d2_at)   data_in = d2;
            if (i == drop_at) data_valid = 1'b0;
            if (i == rst_at)  reset = 1'b1;
            if (i == rel_at)  reset = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single all-ones word
        offer(4'b1111);
        cap(8, -1, '0, 0, -1, -1);
        chk("A_ts", 0, cts[0], 64'h0F);
        chk("A_bo", 0, cbo[0], 64'h0F);
        chk("A_fd", 0, cfd[0], 64'h08);
        chk("A_busy", 0, cbz[0], 64'h1F);
        chk("A_busy", 1, cbz[1], 64'h7F);
        repeat (3) @(negedge clk);

        // LSB-first ordering
        offer(4'b0110);
        cap(8, -1, '0, 0, -1, -1);
        chk("B_bo", 0, cbo[0], 64'h06);
        chk("B_bo", 1, cbo[1], 64'h06);
        repeat (3) @(negedge clk);

        // Back-to-back with a third word offered while hold is full
        offer(4'b1111);
        cap(14, 0, 4'b0101, 2, -1, -1);
        chk("C_ts", 0, cts[0], 64'h1EF);
        chk("C_bo", 0, cbo[0], 64'h0AF);
        chk("C_fd", 0, cfd[0], 64'h108);
        chk("C_dr_held", 0, 64'(cdr[0][1]), 64'h0);
        chk("C_dr_drain", 0, 64'(cdr[0][5]), 64'h1);
        chk("C_ts", 1, cts[1], 64'h78F);
        chk("C_bo", 1, cbo[1], 64'h28F);
        repeat (3) @(negedge clk);

        // Reset mid-frame with hold full
        offer(4'b1111);
        cap(8, 0, 4'b0101, 1, 1, 3);
        chk("D_ts", 0, cts[0], 64'h03);
        chk("D_ts", 1, cts[1], 64'h03);
        chk("D_dr_rst", 0, 64'(cdr[0][2]), 64'h0);
        chk("D_dr_rel", 0, 64'(cdr[0][4]), 64'h1);
        chk("D_busy", 0, cbz[0], 64'h03);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 199) == 0);
            data_valid = ($urandom_range(0, 2) != 0);
            data_in    = W'($urandom);
        end
        @(negedge clk);
        reset      = 1'b0;
        data_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Parallel-to-serial framer directly upstream of the bit-serial adder stage. Accepts WIDTH-bit words over a valid/ready handshake and emits each word LSB-first, one bit per clock on bit_out, with tx_start held high for exactly WIDTH cycles per frame. Enforces an idle gap between frames so the downstream stage sees a tx_start low phase between words. A one-word holding register lets the next word be accepted while the current frame shifts.

Parameters:
WIDTH, 4, bits per word/frame (>=2)
GAP_CYCLES, 1, tx_start-low cycles forced between consecutive frames (>=1)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in valid this cycle
data_ready  output  1  block can accept a word this cycle
tx_start  output  1  frame-active qualifier to downstream serial stage
bit_out  output  1  serial data bit, LSB first
frame_done  output  1  one-cycle pulse coincident with last bit of a frame
busy  output  1  high in SHIFT or GAP, or while holding register full

Behaviour:
- One clock (clk); reset synchronous, active-high; all state updates on rising clk.
- Reset (sampled high at an edge): state=IDLE, shift reg=0, bit counter=0, gap counter=0, hold_full=0; after that edge tx_start=0, bit_out=0, frame_done=0, busy=0. data_ready=0 while reset is high, 1 on the first cycle after reset deasserts.
- data_ready = !hold_full && !reset (combinational). Transfer occurs at an edge where data_valid && data_ready.
- All of tx_start, bit_out, frame_done are registered.
- States: IDLE, SHIFT, GAP.
- IDLE: transfer at edge E loads data_in directly into shift reg (hold untouched) -> SHIFT; cycle after E: tx_start=1, bit_out=data_in[0].
- SHIFT: bit counter k=0..WIDTH-1; cycle k drives bit_out=word[k], tx_start=1. frame_done=1 only in cycle k=WIDTH-1. After cycle WIDTH-1 -> GAP.
- GAP: tx_start=0, bit_out=0, frame_done=0 for exactly GAP_CYCLES cycles. At end: if hold_full, move hold into shift reg, clear hold_full, -> SHIFT (next frame starts on the next cycle); else -> IDLE.
- Transfer during SHIFT or GAP: word written to hold, hold_full=1, data_ready drops next cycle; stays low until hold drains at end of GAP.
- Frame-to-frame spacing with back-to-back words: exactly WIDTH+GAP_CYCLES cycles between tx_start rising edges; tx_start never high for more than WIDTH consecutive cycles.
- Transfer on the same edge GAP ends into IDLE with hold empty: treated as IDLE acceptance (goes straight to shift reg).
- data_valid while data_ready=0: ignored, no state change; data_in need not be held stable.
- Reset mid-frame: frame abandoned; tx_start=0 from the cycle after the reset edge; hold content discarded; downstream sees a truncated frame.
- busy = (state!=IDLE) || hold_full.

Test Plan:
- Reset then single word 4'b1111 valid one cycle (WIDTH=4, GAP=1) -> tx_start high 4 cycles, bit_out 1,1,1,1, frame_done on 4th, then tx_start low, busy drops after gap.
- Word 4'b0110 -> bit_out sequence 0,1,1,0 LSB first; bit_out=0 outside frame.
- Back-to-back 4'b1111 then 4'b0101 with data_valid held -> second accepted into hold during first frame, data_ready low until gap end; tx_start pattern 1111 0 1111, second frame bits 1,0,1,0.
- Third word offered while hold full -> data_ready=0, word ignored; only two frames emitted.
- Reset asserted during bit 2 of a frame with hold full -> tx_start=0 next cycle, no further frames, data_ready=1 after reset release.
- GAP_CYCLES=3, two queued words -> exactly 3 tx_start-low cycles between frames; rising edges 7 cycles apart.
